neuron_mac_engine: RTL and testbench

//  Generic fully-connected neuron for the FNN accelerator. It holds NUM_WEIGHT runtime-loadable weights
//  and a runtime-loadable bias, and streams NUM_WEIGHT inputs through a 3-stage saturating MAC pipeline.
//  It adds the bias, then applies a runtime-selected activation (linear/ReLU).
//  One result is returned per input vector over a valid/ready handshake. It is instantiated per neuron inside

---
 rtl/nn_pkg.sv | 49 ++++
 rtl/neuron_wmem.sv | 24 ++
 rtl/neuron_mac_engine.sv | 144 ++++++++++++++
 tb/tb_neuron_mac_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and saturating arithmetic helpers for the FNN neuron engines.
// Helpers work on sign-extended 64-bit values and clamp to a w-bit signed range.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_ACT   = 3'd4,
        ST_OUT   = 3'd5
    } neuron_state_e;

    typedef enum logic [1:0] {
        ACT_LIN  = 2'd0,
        ACT_RELU = 2'd1
    } act_mode_e;

    // Operands must already lie inside the w-bit range, so clamping the exact sum
    // is the same as the sign-based overflow rule.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] sum, hi, lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi)
            sat_add = hi;
        else if (sum < lo)
            sat_add = lo;
        else
            sat_add = sum;
    endfunction

    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] a,
                                                      input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (a > hi)
            sat_narrow = hi;
        else if (a < lo)
            sat_narrow = lo;
        else
            sat_narrow = a;
    endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Weight store: one write port, one synchronous read port.
// Contents are deliberately not reset; the read register is the MAC's first stage.
module neuron_wmem #(
    parameter int DEPTH  = 30,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/neuron_mac_engine.sv
// Fully-connected neuron: streams NUM_WEIGHT inputs through a 3-stage saturating MAC,
// adds a bias, applies linear/ReLU activation and returns one result per vector.
module neuron_mac_engine
    import nn_pkg::*;
#(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 30,
    parameter int DATA_W     = 16,
    parameter int INT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cfg_layer,
    input  logic [31:0]       cfg_neuron,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic [1:0]        act_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int F     = DATA_W - INT_W;
    localparam int ACC_W = 2 * DATA_W;
    localparam int AW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

    neuron_state_e state, nxt;

    logic [AW-1:0]            w_ptr, rd_cnt, rd_addr;
    logic signed [DATA_W-1:0] bias, x_s1, w_s1;
    logic signed [ACC_W-1:0]  prod_s2, acc;
    logic [1:0]               vld_pipe;
    logic                     relu_q, in_hs, last_hs, cfg_hit, we;
    logic signed [63:0]       acc_ext, prod_ext, bias_ext, mac_sum, bias_sum, narrow;
    logic [DATA_W-1:0]        act_val;

    assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
    assign busy     = (state != ST_IDLE);
    assign in_hs    = in_valid && in_ready;
    assign last_hs  = in_hs && (state == ST_ACCUM) && (rd_cnt == AW'(NUM_WEIGHT - 1));
    assign cfg_hit  = (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO)) &&
                      (state == ST_IDLE);
    assign we       = cfg_hit && w_valid;
    // The first element of a vector arrives in IDLE, before rd_cnt has advanced.
    assign rd_addr  = (state == ST_IDLE) ? '0 : rd_cnt;

    neuron_wmem #(
        .DEPTH (NUM_WEIGHT),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_wmem (
        .clk  (clk),
        .we   (we),
        .waddr(w_ptr),
        .wdata(w_data),
        .raddr(rd_addr),
        .rdata(w_s1)
    );

    always_comb begin
        acc_ext  = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
        prod_ext = {{(64 - ACC_W){prod_s2[ACC_W-1]}}, prod_s2};
        bias_ext = {{(64 - DATA_W){bias[DATA_W-1]}}, bias};
        mac_sum  = sat_add(acc_ext, prod_ext, ACC_W);
        bias_sum = sat_add(acc_ext, bias_ext <<< F, ACC_W);
        narrow   = sat_narrow(acc_ext >>> F, DATA_W);
        act_val  = (relu_q && narrow[63]) ? '0 : narrow[DATA_W-1:0];
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (in_hs) nxt = ST_ACCUM;
            ST_ACCUM: if (last_hs) nxt = ST_DRAIN;
            ST_DRAIN: if (vld_pipe == '0) nxt = ST_BIAS;
            ST_BIAS:  nxt = ST_ACT;
            ST_ACT:   nxt = ST_OUT;
            ST_OUT:   if (out_ready) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            rd_cnt    <= '0;
            bias      <= '0;
            relu_q    <= 1'b0;
            x_s1      <= '0;
            prod_s2   <= '0;
            acc       <= '0;
            vld_pipe  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (we)
                w_ptr <= (w_ptr == AW'(NUM_WEIGHT - 1)) ? '0 : w_ptr + 1'b1;
            if (cfg_hit && b_valid)
                bias <= b_data;

            vld_pipe <= {vld_pipe[0], in_hs};
            if (in_hs)
                x_s1 <= in_data;
            prod_s2 <= ACC_W'(x_s1) * ACC_W'(w_s1);

            if (in_hs) begin
                if (state == ST_IDLE) begin
                    rd_cnt <= AW'(1);
                    relu_q <= (act_mode != ACT_LIN);
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end

            case (state)
                ST_BIAS: acc <= bias_sum[ACC_W-1:0];
                ST_ACT: begin
                    out_data  <= act_val;
                    out_valid <= 1'b1;
                end
                ST_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                end
                default: if (vld_pipe[1]) acc <= mac_sum[ACC_W-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Bench for neuron_mac_engine: directed table, stall/config/reset sequences,
// and random vectors scored against an arithmetic reference model.
module tb_neuron_mac_engine;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_layer, cfg_neuron;
    logic        w_valid, b_valid, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] w_data, b_data, in_data, out_data;
    logic [1:0]  act_mode;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the configurable state: weight RAM, write pointer and bias.
    logic [15:0] m_ram [NW];
    int          m_ptr  = 0;
    logic [15:0] m_bias = 16'h0;

    typedef struct {
        string       name;
        logic [15:0] w;
        logic [15:0] b;
        logic [1:0]  m;
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;

    neuron_mac_engine #(
        .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_W(16), .INT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
        .act_mode(act_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input string nm, input logic [15:0] w, input logic [15:0] b,
                                input logic [1:0] m, input logic [15:0] x, input logic [15:0] e);
        vec_t v;
        v.name = nm; v.w = w; v.b = b; v.m = m; v.x = x; v.exp = e;
        return v;
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Q4.12 neuron: exact products, accumulator clamped to 32 bits after every add,
    // bias scaled by 2^12, floor-divide by 2^12, clamp to 16 bits, optional ReLU.
    function automatic logic [15:0] ref_out(input logic [15:0] w [NW], input logic [15:0] x [NW],
                                            input logic [15:0] b, input logic [1:0] m);
        longint acc, r;
        acc = 0;
        for (int i = 0; i < NW; i++) begin
            acc = acc + longint'($signed(w[i])) * longint'($signed(x[i]));
            acc = clamp(acc, -64'sd2147483648, 64'sd2147483647);
        end
        acc = clamp(acc + longint'($signed(b)) * 4096, -64'sd2147483648, 64'sd2147483647);
        r = clamp(acc >>> 12, -32768, 32767);
        if (m != 2'd0 && r < 0)
            r = 0;
        return r[15:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input bit dow, input logic [15:0] wv, input bit dob,
                             input logic [15:0] bv, input int layer, input int neuron);
        cfg_layer = 32'(layer); cfg_neuron = 32'(neuron);
        w_valid = dow; w_data = wv; b_valid = dob; b_data = bv;
        tick();
        w_valid = 1'b0; b_valid = 1'b0;
        cfg_layer = 32'd1; cfg_neuron = 32'd0;
        if (layer == 1 && neuron == 0) begin
            if (dow) begin
                m_ram[m_ptr] = wv;
                m_ptr = (m_ptr + 1) % NW;
            end
            if (dob)
                m_bias = bv;
        end
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < NW; i++)
            cfg_write(1'b1, w, (i == NW - 1), b, 1, 0);
    endtask

    task automatic run_vec(input logic [15:0] xs [NW], input logic [1:0] mode, input bit gaps,
                           input int hold, output logic [15:0] res);
        int n, guard, lat;
        bit hs, ok;
        logic [15:0] held;
        n = 0; guard = 0; lat = 0; ok = 1'b1;
        act_mode = mode;
        while (n < NW && guard < 200) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = xs[n];
            hs = in_valid && in_ready;
            tick();
            guard++;
            if (hs) begin
                n++;
                if (n == 1)
                    act_mode = ~mode;
            end
        end
        in_valid = 1'b0;
        check("all_accepted", 32'(n), 32'(NW));
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        held = out_data;
        for (int k = 0; k < hold; k++) begin
            if (k == 3) begin
                cfg_layer = 32'd1; cfg_neuron = 32'd0;
                w_valid = 1'b1; b_valid = 1'b1; w_data = 16'h7777; b_data = 16'h7777;
            end
            tick();
            w_valid = 1'b0; b_valid = 1'b0;
            if (!(out_valid && out_data == held && !in_ready && busy))
                ok = 1'b0;
        end
        if (hold > 0)
            check("hold_stable", 32'(ok), 32'd1);
        res = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_dropped", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t        tbl [6];
        logic [15:0] xs [NW];
        logic [15:0] res, exp;
        logic [1:0]  md;

        cfg_layer = 32'd1; cfg_neuron = 32'd0;
        w_valid = 1'b0; b_valid = 1'b0; w_data = '0; b_data = '0;
        act_mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        tbl[0] = mk("t1_linear",   16'h1000, 16'h0400, 2'd0, 16'h0800, 16'h2400);
        tbl[1] = mk("t2_relu",     16'h1000, 16'hE000, 2'd1, 16'h0500, 16'h0000);
        tbl[2] = mk("t2_linear",   16'h1000, 16'hE000, 2'd0, 16'h0500, 16'hF400);
        tbl[3] = mk("t2_mode3",    16'h1000, 16'hE000, 2'd3, 16'h0500, 16'h0000);
        tbl[4] = mk("t3_sat_pos",  16'h7FFF, 16'h0000, 2'd0, 16'h7FFF, 16'h7FFF);
        tbl[5] = mk("t3_sat_neg",  16'h8001, 16'h0000, 2'd0, 16'h7FFF, 16'h8000);
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].w, tbl[i].b);
            for (int j = 0; j < NW; j++)
                xs[j] = tbl[i].x;
            run_vec(xs, tbl[i].m, 1'b0, 0, res);
            check(tbl[i].name, 32'(res), 32'(tbl[i].exp));
        end

        // Output stall with a config write attempted while busy.
        load(16'h1000, 16'h0400);
        for (int j = 0; j < NW; j++)
            xs[j] = 16'h0800;
        run_vec(xs, 2'd0, 1'b0, 10, res);
        check("t4_stall_result", 32'(res), 32'h2400);
        run_vec(xs, 2'd0, 1'b0, 0, res);
        check("t5_busy_write_ignored", 32'(res), 32'h2400);

        // Writes addressed to another neuron or layer are ignored.
        cfg_write(1'b1, 16'h7777, 1'b1, 16'h7777, 1, 5);
        cfg_write(1'b1, 16'h7777, 1'b1, 16'h7777, 2, 0);
        run_vec(xs, 2'd0, 1'b1, 0, res);
        check("t5_addr_write_ignored", 32'(res), 32'h2400);

        // Reset mid-vector: abort, bias and pointer cleared, RAM kept.
        act_mode = 2'd0; in_valid = 1'b1; in_data = 16'h0800;
        tick();
        tick();
        in_valid = 1'b0;
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        m_ptr = 0; m_bias = 16'h0;
        run_vec(xs, 2'd0, 1'b0, 0, res);
        check("t6_bias_cleared", 32'(res), 32'h2000);
        cfg_write(1'b0, 16'h0, 1'b1, 16'h0400, 1, 0);
        run_vec(xs, 2'd0, 1'b0, 0, res);
        check("t6_after_rst", 32'(res), 32'h2400);

        // Five writes: pointer wraps and slot 0 is overwritten with 3.0.
        cfg_write(1'b1, 16'h2000, 1'b0, 16'h0, 1, 0);
        cfg_write(1'b1, 16'h1000, 1'b0, 16'h0, 1, 0);
        cfg_write(1'b1, 16'h1000, 1'b0, 16'h0, 1, 0);
        cfg_write(1'b1, 16'h1000, 1'b0, 16'h0, 1, 0);
        cfg_write(1'b1, 16'h3000, 1'b0, 16'h0, 1, 0);
        run_vec(xs, 2'd0, 1'b0, 0, res);
        check("t5_ptr_wrap", 32'(res), 32'h3400);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NW; i++) begin
                w_data = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
                cfg_write(1'b1, w_data, 1'b0, 16'h0, 1, 0);
                xs[i] = (r % 3 == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            end
            b_data = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
            cfg_write(1'b0, 16'h0, 1'b1, b_data, 1, 0);
            md = 2'($urandom_range(0, 3));
            exp = ref_out(m_ram, xs, m_bias, md);
            run_vec(xs, md, 1'($urandom_range(0, 1)), 0, res);
            check($sformatf("rand_%0d", r), 32'(res), 32'(exp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
